// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator.
// Opcodes (OP_LOAD/OP_ADD/OP_SUB/OP_CLEAR) and the two-state output FSM
// encoding (IDLE/RESULT), plus the signed-saturation helper used when the
// design is built with ADDSUB_ACC_SAT_EN.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_e;

  // Returns 1 when the signed extreme should be the positive one (0111..1);
  // overflow can only push past the extreme on the side of operand a's sign.
  function automatic logic sat_positive(input logic a_msb);
    return ~a_msb;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple adder-subtractor.
//   a, b  : WIDTH-bit operands
//   sub   : 1 selects a - b (b inverted, carry-in forced to 1)
//   sum   : WIDTH-bit result
//   carry : carry-out of the top bit (for subtract, 1 = no borrow)
//   ovf   : two's-complement signed overflow
// One full-adder instance per bit, chained through c[].

module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  assign bx   = b ^ {WIDTH{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    addsub_fa u_fa (
      .a   (a[i]),
      .b   (bx[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  assign carry = c[WIDTH];
  // Same-signed inputs producing a differently-signed result.
  assign ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator stage around addsub_core with valid/ready on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : command handshake; in_op, in_data = command
//   out_valid/out_ready : result handshake
//   out_acc             : accumulator after the command
//   out_carry, out_ovf  : adder carry-out / signed overflow (0 for LOAD/CLEAR)
//   out_zero            : out_acc == 0
// Build option: define ADDSUB_ACC_SAT_EN to saturate ADD/SUB results on
// signed overflow instead of wrapping.
// A result is registered on the accepting edge; in_ready opens whenever the
// output register is empty or being drained this cycle, so a pop and a push
// can share one edge with no bubble.

module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);
  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic             sum_carry, sum_ovf, sub, accept;
  logic [WIDTH-1:0] nxt_acc;
  logic             nxt_carry, nxt_ovf;

  assign sub      = (in_op == OP_SUB);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_acc  = acc;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (acc),
    .b    (in_data),
    .sub  (sub),
    .sum  (sum),
    .carry(sum_carry),
    .ovf  (sum_ovf)
  );

  always_comb begin
    nxt_acc   = '0;
    nxt_carry = 1'b0;
    nxt_ovf   = 1'b0;
    case (in_op)
      OP_LOAD: nxt_acc = in_data;
      OP_ADD, OP_SUB: begin
        nxt_carry = sum_carry;
        nxt_ovf   = sum_ovf;
`ifdef ADDSUB_ACC_SAT_EN
        if (sum_ovf)
          nxt_acc = sat_positive(acc[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}};
        else
          nxt_acc = sum;
`else
        nxt_acc = sum;
`endif
      end
      default: nxt_acc = '0; // CLEAR: operand ignored
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      acc       <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      // Outputs only move on accept, so they hold while back-pressured.
      if (accept) begin
        acc       <= nxt_acc;
        out_carry <= nxt_carry;
        out_ovf   <= nxt_ovf;
        out_zero  <= (nxt_acc == '0);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RESULT;
            out_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (out_ready && !accept) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_accumulator.sv
module tb_addsub_accumulator;
  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int SMAX = (1 << (W-1)) - 1;
  localparam int SMIN = -(1 << (W-1));
  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

  logic         clk = 0, rst_n = 0;
  logic         in_valid = 0, out_ready = 1;
  logic [1:0]   in_op = 0;
  logic [W-1:0] in_data = 0;
  logic         in_ready, out_valid, out_carry, out_ovf, out_zero;
  logic [W-1:0] out_acc;

  int n_cmp = 0, n_err = 0;

  // Reference model: integer arithmetic on signed/unsigned interpretations.
  int   m_acc = 0;
  logic m_valid = 0, m_carry = 0, m_ovf = 0;

  addsub_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  function automatic int to_s(input int u);
    return (u > SMAX) ? u - MOD : u;
  endfunction

  function automatic logic [W+3:0] exp_vec();
    logic [W-1:0] a;
    a = m_acc[W-1:0];
    return {m_valid, a, m_carry, m_ovf, (m_acc == 0)};
  endfunction

  task automatic m_reset();
    m_acc = 0; m_valid = 0; m_carry = 0; m_ovf = 0;
  endtask

  task automatic m_apply(input logic [1:0] op, input logic [W-1:0] d);
    int a, b, sr;
    a = m_acc; b = int'(d); sr = 0;
    m_carry = 0; m_ovf = 0;
    case (op)
      LD: m_acc = b;
      CL: m_acc = 0;
      AD: begin
        m_carry = (a + b) >= MOD;
        m_acc   = (a + b) % MOD;
        sr      = to_s(a) + to_s(b);
      end
      default: begin
        m_carry = (a >= b);
        m_acc   = (a - b + MOD) % MOD;
        sr      = to_s(a) - to_s(b);
      end
    endcase
    if (op == AD || op == SB) m_ovf = (sr > SMAX) || (sr < SMIN);
`ifdef ADDSUB_ACC_SAT_EN
    if (m_ovf) m_acc = (sr > 0) ? SMAX : (SMIN + MOD);
`endif
    m_valid = 1;
  endtask

  // Present one command, clock it in (out_ready assumed 1), leave valid high.
  task automatic send(input logic [1:0] op, input logic [W-1:0] d);
    in_valid = 1; in_op = op; in_data = d;
    @(posedge clk); #1;
    m_apply(op, d);
  endtask

  task automatic test_reset();
    rst_n = 0; #2;
    n_cmp++;
    if ({out_valid, out_acc, out_carry, out_ovf, out_zero} !== '0) begin
      n_err++; $display("FAIL reset_init got %b want 0", {out_valid, out_acc, out_carry, out_ovf, out_zero});
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    send(LD, 4'b0110); in_valid = 0;
    n_cmp++;
    if (!out_valid) begin n_err++; $display("FAIL pending_before_reset got out_valid=0 want 1"); end
    out_ready = 0; #2; rst_n = 0; #1;   // asynchronous, between edges
    m_reset();
    n_cmp++;
    if ({out_valid, out_acc, out_carry, out_ovf, out_zero} !== '0) begin
      n_err++; $display("FAIL reset_mid got %b want 0", {out_valid, out_acc, out_carry, out_ovf, out_zero});
    end
    @(negedge clk); rst_n = 1; out_ready = 1;
    @(negedge clk);
    send(AD, 4'b0001); in_valid = 0;
    n_cmp++;
    if (exp_vec() !== {out_valid, out_acc, out_carry, out_ovf, out_zero} || out_acc !== 4'b0001) begin
      n_err++; $display("FAIL add_after_reset got acc=%b want %b", out_acc, 4'b0001);
    end
  endtask

  task automatic test_arith();
    send(LD, 4'b0101);
    send(AD, 4'b0011);
    n_cmp++;
`ifdef ADDSUB_ACC_SAT_EN
    if ({out_acc, out_carry, out_ovf, out_zero} !== {4'b0111, 1'b0, 1'b1, 1'b0}) begin
`else
    if ({out_acc, out_carry, out_ovf, out_zero} !== {4'b1000, 1'b0, 1'b1, 1'b0}) begin
`endif
      n_err++; $display("FAIL add_ovf got acc=%b c=%b v=%b z=%b", out_acc, out_carry, out_ovf, out_zero);
    end
    send(LD, 4'b1000);
    send(SB, 4'b1000);
    n_cmp++;
    if ({out_acc, out_carry, out_ovf, out_zero} !== {4'b0000, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL sub_to_zero got acc=%b c=%b v=%b z=%b want 0000 1 0 1", out_acc, out_carry, out_ovf, out_zero);
    end
    send(SB, 4'b0001);
    n_cmp++;
    if ({out_acc, out_carry, out_ovf, out_zero} !== {4'b1111, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL sub_borrow got acc=%b c=%b v=%b z=%b want 1111 0 0 0", out_acc, out_carry, out_ovf, out_zero);
    end
    send(LD, 4'b1000);
    send(SB, 4'b0001);
    n_cmp++;
`ifdef ADDSUB_ACC_SAT_EN
    if ({out_acc, out_ovf} !== {4'b1000, 1'b1}) begin
`else
    if ({out_acc, out_ovf} !== {4'b0111, 1'b1}) begin
`endif
      n_err++; $display("FAIL sub_neg_ovf got acc=%b v=%b", out_acc, out_ovf);
    end
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [W+3:0] held;
    send(LD, 4'b0010);
    held = {out_valid, out_acc, out_carry, out_ovf, out_zero};
    out_ready = 0; in_valid = 1; in_op = AD; in_data = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, out_acc, out_carry, out_ovf, out_zero} !== exp_vec()) begin
        n_err++; $display("FAIL bp_hold cyc%0d got %b want %b", i, {out_valid, out_acc, out_carry, out_ovf, out_zero}, exp_vec());
      end
    end
    n_cmp++;
    if (held !== exp_vec()) begin n_err++; $display("FAIL bp_snapshot got %b want %b", held, exp_vec()); end
    out_ready = 1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    m_apply(AD, 4'b0011);
    in_valid = 0;
    n_cmp++;
    if ({out_valid, out_acc, out_carry, out_ovf, out_zero} !== exp_vec() || out_acc !== 4'b0101) begin
      n_err++; $display("FAIL bp_pop_push got %b want %b", {out_valid, out_acc, out_carry, out_ovf, out_zero}, exp_vec());
    end
    @(posedge clk); #1;
    m_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want [3];
    logic [1:0]   ops  [3];
    logic [W-1:0] ds   [3];
    ops = '{CL, AD, AD}; ds = '{4'b1010, 4'b1111, 4'b0001};
    want = '{4'b0000, 4'b1111, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], ds[i]);
      n_cmp++;
      if ({out_valid, out_acc} !== {1'b1, want[i]} || exp_vec() !== {out_valid, out_acc, out_carry, out_ovf, out_zero}) begin
        n_err++; $display("FAIL b2b_%0d got v=%b acc=%b want 1 %b", i, out_valid, out_acc, want[i]);
      end
    end
    n_cmp++;
    if ({out_carry, out_zero} !== 2'b11) begin
      n_err++; $display("FAIL wrap_flags got c=%b z=%b want 1 1", out_carry, out_zero);
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    logic acc_ok;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_data   = W'($urandom);
      #1;
      acc_ok = in_valid && (!m_valid || out_ready);
      n_cmp++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_err++; $display("FAIL rnd_in_ready i=%0d got %b want %b", i, in_ready, !m_valid || out_ready);
      end
      @(posedge clk); #1;
      if (acc_ok) m_apply(in_op, in_data);
      else if (out_ready) m_valid = 0;
      n_cmp++;
      if ({out_valid, out_acc, out_carry, out_ovf, out_zero} !== exp_vec()) begin
        n_err++; $display("FAIL rnd_out i=%0d got %b want %b", i, {out_valid, out_acc, out_carry, out_ovf, out_zero}, exp_vec());
      end
    end
    in_valid = 0; out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_arith();
    @(posedge clk); #1; m_valid = 0;
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Sequential accumulator stage wrapped around a ripple add/subtract datapath.
- Accepts a stream of (opcode, operand) commands over a valid/ready handshake and applies each to an internal accumulator register as accumulator ± operand.
- Presents each registered result and its flags downstream over a second valid/ready handshake.
- Feeds the adder-subtractor and consumes its sum/carry, adding registering, flag generation and flow control.

Parameters:
- WIDTH, 4, datapath width in bits of operand, accumulator and result; legal values ≥ 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command this cycle.
- in_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- in_data  input  WIDTH  operand; ignored for CLEAR.
- out_valid  output  1  result registered and pending.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  WIDTH  accumulator value after the command.
- out_carry  output  1  carry-out of the adder; for SUB, 1 means no borrow.
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_acc == 0.

Behaviour:
- Reset:
  - The reset is asynchronous and active-low; there is one clock, clk.
  - While rst_n is low: acc = 0, out_valid = 0, out_acc = 0, out_carry = 0, out_ovf = 0, out_zero = 0, FSM in IDLE.
  - Reset asserted mid-transaction discards any pending result with no handshake completion.
- Accept:
  - in_ready = !out_valid || out_ready (combinational).
  - A command is accepted when in_valid && in_ready at a rising clk edge.
- Latency: the result appears on out_* with out_valid = 1 on the edge that accepts the command, so it is visible the cycle after presentation. One command is in flight at a time.
- Datapath:
  - Internal adder computes acc + (in_data ^ {WIDTH{sub}}) + sub, where sub = (in_op == SUB).
  - Carry is bit WIDTH of the sum.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the inverted operand for SUB.
- Opcode rules:
  - ADD/SUB: acc ← sum[WIDTH-1:0], with carry and ovf as computed.
  - LOAD: acc ← in_data, carry = 0, ovf = 0.
  - CLEAR: acc ← 0, carry = 0, ovf = 0.
  - out_zero is always derived from the new acc.
- FSM:
  - IDLE (out_valid = 0) → RESULT on accept.
  - RESULT (out_valid = 1) → IDLE on out_ready && !accept.
  - RESULT → RESULT on out_ready && accept, with new data loaded and no bubble.
  - RESULT holds on !out_ready: all out_* stable and in_ready = 0.
- Wrap-around: results are modulo 2^WIDTH; accumulator value 2^WIDTH-1 plus 1 gives 0, carry 1, zero 1.
- Simultaneous events: a downstream pop and an upstream push in the same cycle are both honoured.
- Illegal/X: in_data X is tolerated for CLEAR only.

Optional Feature:
- Macro: ADDSUB_ACC_SAT_EN.
- Defined: on ADD/SUB with ovf = 1, acc saturates to the signed extreme, following the sign of a.
  - Positive overflow gives 0111…1.
  - Negative overflow gives 1000…0.
  - out_ovf still reports 1; out_carry reports the raw adder carry.
- Undefined: results wrap modulo 2^WIDTH.

Decomposition:
- Package addsub_pkg holds:
  - Opcode enum/localparams OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLEAR = 2'b11.
  - FSM state encoding IDLE/RESULT.
- Sub-module addsub_core: parameterised WIDTH, combinational ripple adder-subtractor (a, b, sub → sum, carry, ovf), built from a chain of full adders with b XOR sub and carry-in = sub.
- The top level holds the registers, FSM and handshake only.

Test Plan (WIDTH = 4, out_ready = 1 unless stated):
- Reset mid-pending: pulse rst_n low while out_valid = 1 → out_valid = 0 and out_acc = 0 immediately; next ADD 0001 → out_acc = 0001.
- LOAD 0101, then ADD 0011 → out_acc = 1000, carry = 0, ovf = 1, zero = 0 (without macro).
- From 1000, SUB 1000 → out_acc = 0000, carry = 1, ovf = 0, zero = 1; then SUB 0001 → out_acc = 1111, carry = 0, ovf = 0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid held high → in_ready = 0, out_* stable; on out_ready = 1, pop and next accept in the same cycle with out_valid staying 1.
- Back-to-back: CLEAR, ADD 1111, ADD 0001 on consecutive cycles → results 0000, 1111, 0000 (carry = 1, zero = 1), one per cycle.
- With ADDSUB_ACC_SAT_EN:
  - LOAD 0101, ADD 0011 → out_acc = 0111, ovf = 1.
  - LOAD 1000, SUB 0001 → out_acc = 1000, ovf = 1.
